// File: rtl/readout_rx_classifier_sequencer.sv
// ---------------------------------------------------------------------------
// readout_rx_classifier_sequencer
//
// Runs one readout measurement at a time in front of the single-line IQ state
// classifier. For each accepted request it loads the qubit's y-intercept and
// slope from a local coefficient table into the classifier. It then forwards
// exactly N I/Q samples framed by start/finish strobes, counts the |1>
// decisions the classifier reports, and returns a thresholded state per
// request.
//
// Ports:
//   i_clk, i_rst                    clock, asynchronous active-high reset
//   i_tbl_wr_*                      coefficient table write port (any state)
//   i_req_* / o_req_ready           measurement request handshake
//   i_iq_valid_in, i_i_in, i_q_in   demodulator sample stream
//   o_cls_coeff_wr_*                classifier coefficient write port
//   o_cls_valid/start/finish, o_cls_i/q  classifier sample input
//   i_cls_valid_out, i_cls_finish_count_out, i_cls_count_condition
//                                   classifier decision outputs
//   o_res_* / i_res_ready           per-measurement result handshake
//   o_busy                          high whenever a measurement is in flight
// ---------------------------------------------------------------------------
module readout_rx_classifier_sequencer #(
    parameter int DATA_WIDTH         = 16,
    parameter int NUM_QUBITS         = 4,
    parameter int QUBIT_ID_WIDTH     = 2,
    parameter int SAMPLE_COUNT_WIDTH = 10
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_tbl_wr_en,
    input  logic [QUBIT_ID_WIDTH-1:0]     i_tbl_wr_qubit,
    input  logic                          i_tbl_wr_sel,
    input  logic [DATA_WIDTH-1:0]         i_tbl_wr_data,
    input  logic                          i_req_valid,
    output logic                          o_req_ready,
    input  logic [QUBIT_ID_WIDTH-1:0]     i_req_qubit,
    input  logic [SAMPLE_COUNT_WIDTH-1:0] i_req_num_samples,
    input  logic [SAMPLE_COUNT_WIDTH-1:0] i_req_threshold,
    input  logic                          i_iq_valid_in,
    input  logic [DATA_WIDTH-1:0]         i_i_in,
    input  logic [DATA_WIDTH-1:0]         i_q_in,
    output logic                          o_cls_coeff_wr_en,
    output logic                          o_cls_coeff_wr_addr,
    output logic [DATA_WIDTH-1:0]         o_cls_coeff_wr_data,
    output logic                          o_cls_valid,
    output logic                          o_cls_start_count,
    output logic                          o_cls_finish_count,
    output logic [DATA_WIDTH-1:0]         o_cls_i,
    output logic [DATA_WIDTH-1:0]         o_cls_q,
    input  logic                          i_cls_valid_out,
    input  logic                          i_cls_finish_count_out,
    input  logic                          i_cls_count_condition,
    output logic                          o_res_valid,
    input  logic                          i_res_ready,
    output logic [QUBIT_ID_WIDTH-1:0]     o_res_qubit,
    output logic                          o_res_state,
    output logic [SAMPLE_COUNT_WIDTH-1:0] o_res_count,
    output logic                          o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_B,
        LOAD_A,
        STREAM,
        DRAIN,
        RESULT
    } state_t;

    localparam logic [SAMPLE_COUNT_WIDTH-1:0] ONE = 1;

    state_t                          r_state;
    logic [DATA_WIDTH-1:0]           r_yInt  [NUM_QUBITS];
    logic [DATA_WIDTH-1:0]           r_slope [NUM_QUBITS];
    logic [QUBIT_ID_WIDTH-1:0]       r_qubit;
    logic [SAMPLE_COUNT_WIDTH-1:0]   r_numSamples;
    logic [SAMPLE_COUNT_WIDTH-1:0]   r_threshold;
    logic [SAMPLE_COUNT_WIDTH-1:0]   r_sampleCnt;
    logic [SAMPLE_COUNT_WIDTH-1:0]   r_acc;
    logic                            r_coeffWrEn;
    logic                            r_coeffWrAddr;
    logic [DATA_WIDTH-1:0]           r_coeffWrData;
    logic                            r_resValid;
    logic                            r_resState;

    logic                            w_fwd;
    logic                            w_lastSample;
    logic                            w_hit;
    logic [SAMPLE_COUNT_WIDTH-1:0]   w_accNext;

    // Samples are only forwarded while streaming; everything else is dropped.
    assign w_fwd        = (r_state == STREAM) && i_iq_valid_in;
    assign w_lastSample = (r_sampleCnt == (r_numSamples - ONE));
    assign w_hit        = i_cls_valid_out && i_cls_count_condition;
    assign w_accNext    = r_acc + {{(SAMPLE_COUNT_WIDTH-1){1'b0}}, w_hit};

    assign o_cls_valid         = w_fwd;
    assign o_cls_start_count   = w_fwd && (r_sampleCnt == '0);
    assign o_cls_finish_count  = w_fwd && w_lastSample;
    assign o_cls_i             = i_i_in;
    assign o_cls_q             = i_q_in;
    assign o_cls_coeff_wr_en   = r_coeffWrEn;
    assign o_cls_coeff_wr_addr = r_coeffWrAddr;
    assign o_cls_coeff_wr_data = r_coeffWrData;
    assign o_req_ready         = (r_state == IDLE);
    assign o_busy              = (r_state != IDLE);
    assign o_res_valid         = r_resValid;
    assign o_res_qubit         = r_qubit;
    assign o_res_state         = r_resState;
    assign o_res_count         = r_acc;

    // Coefficient table. Loads read the registered contents, so a write landing
    // in the same cycle as a load only becomes visible to later loads.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_QUBITS; k++) begin
                r_yInt[k]  <= '0;
                r_slope[k] <= '0;
            end
        end else if (i_tbl_wr_en) begin
            if (i_tbl_wr_sel) begin
                r_slope[i_tbl_wr_qubit] <= i_tbl_wr_data;
            end else begin
                r_yInt[i_tbl_wr_qubit] <= i_tbl_wr_data;
            end
        end
    end

    // Measurement sequencer. The coefficient write port is registered, so the
    // value for each load is fetched on the edge that enters the load state.
    // The result count is the accumulator itself, frozen once RESULT is entered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_qubit       <= '0;
            r_numSamples  <= '0;
            r_threshold   <= '0;
            r_sampleCnt   <= '0;
            r_acc         <= '0;
            r_coeffWrEn   <= 1'b0;
            r_coeffWrAddr <= 1'b0;
            r_coeffWrData <= '0;
            r_resValid    <= 1'b0;
            r_resState    <= 1'b0;
        end else begin
            r_coeffWrEn <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_qubit      <= i_req_qubit;
                        r_numSamples <= i_req_num_samples;
                        r_threshold  <= i_req_threshold;
                        r_sampleCnt  <= '0;
                        r_acc        <= '0;
                        if (i_req_num_samples == '0) begin
                            r_state    <= RESULT;
                            r_resValid <= 1'b1;
                            r_resState <= 1'b0;
                        end else begin
                            r_state       <= LOAD_B;
                            r_coeffWrEn   <= 1'b1;
                            r_coeffWrAddr <= 1'b0;
                            r_coeffWrData <= r_yInt[i_req_qubit];
                        end
                    end
                end
                LOAD_B: begin
                    r_state       <= LOAD_A;
                    r_coeffWrEn   <= 1'b1;
                    r_coeffWrAddr <= 1'b1;
                    r_coeffWrData <= r_slope[r_qubit];
                end
                LOAD_A: begin
                    r_state <= STREAM;
                end
                STREAM: begin
                    r_acc <= w_accNext;
                    if (w_fwd) begin
                        r_sampleCnt <= r_sampleCnt + ONE;
                        if (w_lastSample) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    r_acc <= w_accNext;
                    if (i_cls_valid_out && i_cls_finish_count_out) begin
                        r_state    <= RESULT;
                        r_resValid <= 1'b1;
                        r_resState <= (w_accNext > r_threshold);
                    end
                end
                RESULT: begin
                    if (i_res_ready) begin
                        r_state    <= IDLE;
                        r_resValid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_readout_rx_classifier_sequencer.sv
// ---------------------------------------------------------------------------
// tb_readout_rx_classifier_sequencer
//
// Directed bench for the readout classifier sequencer. A small stand-in for
// the classifier (2-cycle pipeline, |1> decision = LSB of the I sample) sits on
// the classifier ports. Each measurement task predicts, cycle by cycle, what
// every DUT output must be from the request, the sample pattern and a model
// coefficient table; a single compare process checks those predictions.
// ---------------------------------------------------------------------------
module tb_readout_rx_classifier_sequencer;

    localparam int DW  = 16;
    localparam int QW  = 2;
    localparam int SCW = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic           tblWrEn;
    logic [QW-1:0]  tblWrQubit;
    logic           tblWrSel;
    logic [DW-1:0]  tblWrData;
    logic           reqValid;
    logic           reqReady;
    logic [QW-1:0]  reqQubit;
    logic [SCW-1:0] reqN;
    logic [SCW-1:0] reqThr;
    logic           iqValid;
    logic [DW-1:0]  iIn;
    logic [DW-1:0]  qIn;
    logic           clsWrEn;
    logic           clsWrAddr;
    logic [DW-1:0]  clsWrData;
    logic           clsValid;
    logic           clsStart;
    logic           clsFinish;
    logic [DW-1:0]  clsI;
    logic [DW-1:0]  clsQ;
    logic           clsValidOut;
    logic           clsFinishOut;
    logic           clsCond;
    logic           resValid;
    logic           resReady;
    logic [QW-1:0]  resQubit;
    logic           resState;
    logic [SCW-1:0] resCount;
    logic           busy;

    // Expected values for the current cycle, written by the stimulus tasks.
    logic           cmpEn;
    logic           expReqReady, expBusy, expWrEn, expWrAddr, expDataZero;
    logic [DW-1:0]  expWrData;
    logic           expValid, expStart, expFinish;
    logic           expResValid, expResCheck, expResState;
    logic [QW-1:0]  expResQubit;
    logic [SCW-1:0] expResCount;

    // Model coefficient table and stimulus tables.
    logic [DW-1:0]  modelY     [4];
    logic [DW-1:0]  modelSlope [4];
    logic [DW-1:0]  sampI      [16];
    logic           validPat   [8];
    int             patLen;

    int             nVectors     = 0;
    int             nMiscompares = 0;
    int             cyc          = 0;
    int             pulseCnt     = 0;
    int             lastT, lastS, lastRes, lastPulseBase;
    logic [DW-1:0]  lastWrY, lastWrS;
    logic [SCW-1:0] lastCount;
    logic           lastState;

    logic [2:0]     pipe1, pipe2;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    readout_rx_classifier_sequencer #(
        .DATA_WIDTH(DW), .NUM_QUBITS(4), .QUBIT_ID_WIDTH(QW), .SAMPLE_COUNT_WIDTH(SCW)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_tbl_wr_en(tblWrEn), .i_tbl_wr_qubit(tblWrQubit),
        .i_tbl_wr_sel(tblWrSel), .i_tbl_wr_data(tblWrData),
        .i_req_valid(reqValid), .o_req_ready(reqReady), .i_req_qubit(reqQubit),
        .i_req_num_samples(reqN), .i_req_threshold(reqThr),
        .i_iq_valid_in(iqValid), .i_i_in(iIn), .i_q_in(qIn),
        .o_cls_coeff_wr_en(clsWrEn), .o_cls_coeff_wr_addr(clsWrAddr),
        .o_cls_coeff_wr_data(clsWrData),
        .o_cls_valid(clsValid), .o_cls_start_count(clsStart),
        .o_cls_finish_count(clsFinish), .o_cls_i(clsI), .o_cls_q(clsQ),
        .i_cls_valid_out(clsValidOut), .i_cls_finish_count_out(clsFinishOut),
        .i_cls_count_condition(clsCond),
        .o_res_valid(resValid), .i_res_ready(resReady), .o_res_qubit(resQubit),
        .o_res_state(resState), .o_res_count(resCount), .o_busy(busy)
    );

    // Classifier stand-in: two register stages, flushed by reset, whose |1>
    // decision is the LSB of the forwarded I sample.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe1 <= 3'b000;
            pipe2 <= 3'b000;
        end else begin
            pipe1 <= {clsValid, clsFinish, clsI[0]};
            pipe2 <= pipe1;
        end
    end
    assign clsValidOut  = pipe2[2];
    assign clsFinishOut = pipe2[1];
    assign clsCond      = pipe2[2] & pipe2[0];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                     name, cyc, actual, expected);
        end
    endtask

    // Compare process: every DUT output against the prediction for this cycle.
    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("req_ready", {31'b0, reqReady}, {31'b0, expReqReady});
            checkOutput("busy", {31'b0, busy}, {31'b0, expBusy});
            checkOutput("coeff_wr_en", {31'b0, clsWrEn}, {31'b0, expWrEn});
            if (expWrEn) begin
                checkOutput("coeff_wr_addr", {31'b0, clsWrAddr}, {31'b0, expWrAddr});
                checkOutput("coeff_wr_data", {16'b0, clsWrData}, {16'b0, expWrData});
            end else if (expDataZero) begin
                checkOutput("coeff_wr_data_rst", {16'b0, clsWrData}, 32'h0);
            end
            checkOutput("cls_valid", {31'b0, clsValid}, {31'b0, expValid});
            checkOutput("cls_start", {31'b0, clsStart}, {31'b0, expStart});
            checkOutput("cls_finish", {31'b0, clsFinish}, {31'b0, expFinish});
            if (expValid) begin
                checkOutput("cls_i", {16'b0, clsI}, {16'b0, iIn});
                checkOutput("cls_q", {16'b0, clsQ}, {16'b0, qIn});
            end
            checkOutput("res_valid", {31'b0, resValid}, {31'b0, expResValid});
            if (expResCheck) begin
                checkOutput("res_qubit", {30'b0, resQubit}, {30'b0, expResQubit});
                checkOutput("res_state", {31'b0, resState}, {31'b0, expResState});
                checkOutput("res_count", {22'b0, resCount}, {22'b0, expResCount});
            end
        end
        if (clsValid) pulseCnt++;
    end

    task automatic expectIdle();
        expReqReady = 1'b1; expBusy = 1'b0;
        expWrEn = 1'b0; expWrAddr = 1'b0; expWrData = '0; expDataZero = 1'b0;
        expValid = 1'b0; expStart = 1'b0; expFinish = 1'b0;
        expResValid = 1'b0; expResCheck = 1'b0;
        expResQubit = '0; expResState = 1'b0; expResCount = '0;
    endtask

    task automatic expectReset();
        expectIdle();
        expDataZero = 1'b1;
        expResCheck = 1'b1;
    endtask

    task automatic expectBusy();
        expectIdle();
        expReqReady = 1'b0;
        expBusy     = 1'b1;
    endtask

    // Advance one cycle and put inputs back to quiet defaults; expectations
    // default to an idle sequencer and are overridden by the caller.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        tblWrEn = 1'b0; tblWrQubit = '0; tblWrSel = 1'b0; tblWrData = '0;
        reqValid = 1'b0; reqQubit = '0; reqN = '0; reqThr = '0;
        iqValid = 1'b0; iIn = '0; qIn = '0;
        resReady = 1'b0;
        expectIdle();
    endtask

    task automatic writeTable(input logic [QW-1:0] q, input logic sel, input logic [DW-1:0] d);
        applyStimulus();
        tblWrEn = 1'b1; tblWrQubit = q; tblWrSel = sel; tblWrData = d;
        if (sel) modelSlope[q] = d;
        else     modelY[q]     = d;
    endtask

    // One measurement: request, coefficient loads, sample stream (pattern from
    // validPat, then back-to-back), drain, result held for holdCycles.
    // abortAt > 0 asserts reset once that many samples have been forwarded.
    task automatic runMeasurement(input logic [QW-1:0] q, input int n, input int thr,
                                  input int holdCycles, input int abortAt,
                                  input bit collide, input logic [DW-1:0] collideData);
        logic [DW-1:0] y, s;
        int fwd, pIdx, hits;
        logic v;
        y = modelY[q];
        s = modelSlope[q];
        fwd = 0; pIdx = 0; hits = 0;
        lastPulseBase = pulseCnt;

        applyStimulus();
        lastT = cyc;
        reqValid = 1'b1; reqQubit = q; reqN = SCW'(n); reqThr = SCW'(thr);
        iqValid = 1'b1; iIn = 16'h0101; qIn = 16'h0202;

        if (n > 0) begin
            applyStimulus();
            expectBusy();
            expWrEn = 1'b1; expWrAddr = 1'b0; expWrData = y;
            iqValid = 1'b1; iIn = 16'h0303; qIn = 16'h0404;
            lastWrY = clsWrData;

            applyStimulus();
            expectBusy();
            expWrEn = 1'b1; expWrAddr = 1'b1; expWrData = s;
            iqValid = 1'b1; iIn = 16'h0505; qIn = 16'h0606;
            lastWrS = clsWrData;
            if (collide) begin
                tblWrEn = 1'b1; tblWrQubit = q; tblWrSel = 1'b1; tblWrData = collideData;
                modelSlope[q] = collideData;
            end

            while (fwd < n) begin
                applyStimulus();
                if (abortAt > 0 && fwd == abortAt) begin
                    rst = 1'b1;
                    iqValid = 1'b1; iIn = 16'h0707;
                    expectReset();
                    applyStimulus();
                    rst = 1'b0;
                    return;
                end
                v = (pIdx < patLen) ? validPat[pIdx] : 1'b1;
                pIdx++;
                expectBusy();
                iqValid = v;
                iIn = sampI[fwd];
                qIn = ~sampI[fwd];
                expValid  = v;
                expStart  = v && (fwd == 0);
                expFinish = v && (fwd == n - 1);
                if (v) begin
                    hits += int'(sampI[fwd][0]);
                    fwd++;
                end
            end
            lastS = cyc;

            repeat (2) begin
                applyStimulus();
                expectBusy();
                iqValid = 1'b1; iIn = 16'h0909;
            end
        end

        for (int h = 0; h <= holdCycles; h++) begin
            applyStimulus();
            expectBusy();
            expResValid = 1'b1; expResCheck = 1'b1;
            expResQubit = q; expResCount = SCW'(hits); expResState = (hits > thr);
            reqValid = 1'b1; iqValid = 1'b1; iIn = 16'h0B0B;
            resReady = (h == holdCycles);
            if (h == 0) begin
                lastRes   = cyc;
                lastCount = resCount;
                lastState = resState;
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        tblWrEn = 1'b0; tblWrQubit = '0; tblWrSel = 1'b0; tblWrData = '0;
        reqValid = 1'b0; reqQubit = '0; reqN = '0; reqThr = '0;
        iqValid = 1'b0; iIn = '0; qIn = '0; resReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            modelY[k] = '0;
            modelSlope[k] = '0;
        end
        // Decision bits (LSBs): 1,0,1,1,0,1,0,1 -> 5 hits over 8 samples.
        sampI[0] = 16'h0011; sampI[1] = 16'h0020; sampI[2] = 16'h0033; sampI[3] = 16'h0101;
        sampI[4] = 16'h7FF0; sampI[5] = 16'h8001; sampI[6] = 16'hFFFE; sampI[7] = 16'h1235;
        for (int k = 8; k < 16; k++) sampI[k] = 16'h0000;
        for (int k = 0; k < 8; k++) validPat[k] = 1'b1;
        patLen = 0;
        expectReset();
        cmpEn = 1'b1;
        @(negedge clk);
        applyStimulus();
        rst = 1'b0;
        applyStimulus();

        // Table load for q2.
        writeTable(2'd2, 1'b0, 16'h0100);
        writeTable(2'd2, 1'b1, 16'h4000);
        runMeasurement(2'd2, 4, 2, 0, 0, 1'b0, 16'h0);
        checkOutput("t1_loadB_data", {16'b0, lastWrY}, 32'h0100);
        checkOutput("t1_loadA_data", {16'b0, lastWrS}, 32'h4000);

        // Counting with backpressure: 5 hits, threshold 4 then 5.
        runMeasurement(2'd0, 8, 4, 10, 0, 1'b0, 16'h0);
        checkOutput("t2_count", {22'b0, lastCount}, 32'd5);
        checkOutput("t2_state", {31'b0, lastState}, 32'd1);
        checkOutput("t2_res_minus_last", 32'(lastRes - lastS), 32'd3);
        checkOutput("t2_req_to_res", 32'(lastRes - lastT), 32'd13);
        runMeasurement(2'd0, 8, 5, 0, 0, 1'b0, 16'h0);
        checkOutput("t3_count", {22'b0, lastCount}, 32'd5);
        checkOutput("t3_state", {31'b0, lastState}, 32'd0);

        // Gapped input 1,0,1,0,1 with N = 3.
        validPat[0] = 1'b1; validPat[1] = 1'b0; validPat[2] = 1'b1;
        validPat[3] = 1'b0; validPat[4] = 1'b1;
        patLen = 5;
        runMeasurement(2'd3, 3, 1, 0, 0, 1'b0, 16'h0);
        checkOutput("t4_pulses", 32'(pulseCnt - lastPulseBase), 32'd3);
        checkOutput("t4_last_sample_cycle", 32'(lastS - lastT), 32'd7);
        checkOutput("t4_count", {22'b0, lastCount}, 32'd2);
        patLen = 0;

        // N = 0 and N = 1.
        runMeasurement(2'd1, 0, 0, 0, 0, 1'b0, 16'h0);
        checkOutput("t5_res_latency", 32'(lastRes - lastT), 32'd1);
        checkOutput("t5_count", {22'b0, lastCount}, 32'd0);
        checkOutput("t5_pulses", 32'(pulseCnt - lastPulseBase), 32'd0);
        runMeasurement(2'd1, 1, 0, 0, 0, 1'b0, 16'h0);
        checkOutput("t6_last_sample_cycle", 32'(lastS - lastT), 32'd3);
        checkOutput("t6_state", {31'b0, lastState}, 32'd1);

        // Slope write colliding with LOAD_A for q1.
        writeTable(2'd1, 1'b1, 16'h1111);
        runMeasurement(2'd1, 2, 0, 0, 0, 1'b1, 16'h2222);
        checkOutput("t7_old_slope", {16'b0, lastWrS}, 32'h1111);
        runMeasurement(2'd1, 2, 0, 0, 0, 1'b0, 16'h0);
        checkOutput("t7_new_slope", {16'b0, lastWrS}, 32'h2222);

        // Reset after 3 of 8 samples, then a fresh measurement.
        runMeasurement(2'd2, 8, 0, 0, 3, 1'b0, 16'h0);
        for (int k = 0; k < 4; k++) begin
            modelY[k] = '0;
            modelSlope[k] = '0;
        end
        applyStimulus();
        runMeasurement(2'd2, 4, 2, 0, 0, 1'b0, 16'h0);
        checkOutput("t8_count", {22'b0, lastCount}, 32'd3);
        checkOutput("t8_state", {31'b0, lastState}, 32'd1);
        checkOutput("t8_req_to_res", 32'(lastRes - lastT), 32'd9);
        checkOutput("t8_table_cleared", {16'b0, lastWrY}, 32'h0);

        applyStimulus();
        applyStimulus();
        @(negedge clk);
        #1;
        cmpEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/readout_rx_classifier_sequencer.md
# readout_rx_classifier_sequencer

Per-measurement sequencer for the readout RX single-line IQ state classifier. It runs one measurement at a time. For each accepted request it loads that qubit's y-intercept and slope from a local coefficient table into the classifier. It then forwards exactly N I/Q samples framed with start/finish strobes, counts the classifier's |1> decisions, and returns a thresholded state decision per request. It sits between the demodulator output and the result/feedback logic, and owns the classifier's coefficient-write and input ports.

## Interface
- DATA_WIDTH, 16, I/Q sample and coefficient width (matches classifier)
- NUM_QUBITS, 4, coefficient table depth
- QUBIT_ID_WIDTH, 2, width of qubit index (log2 NUM_QUBITS)
- SAMPLE_COUNT_WIDTH, 10, width of sample count, threshold and result count
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- tbl_wr_en  in  1  coefficient table write strobe
- tbl_wr_qubit  in  QUBIT_ID_WIDTH  table entry
- tbl_wr_sel  in  1  0 = y_intercept, 1 = slope
- tbl_wr_data  in  DATA_WIDTH  signed coefficient
- req_valid / req_ready  in / out  1  measurement request handshake
- req_qubit  in  QUBIT_ID_WIDTH  qubit to measure
- req_num_samples  in  SAMPLE_COUNT_WIDTH  N, samples to integrate
- req_threshold  in  SAMPLE_COUNT_WIDTH  |1> count threshold
- iq_valid_in  in  1  sample strobe from demodulator
- i_in, q_in  in  DATA_WIDTH  signed samples
- cls_coeff_wr_en  out  1  to classifier coefficient write enable
- cls_coeff_wr_addr  out  1  0 = y_intercept, 1 = slope
- cls_coeff_wr_data  out  DATA_WIDTH  coefficient value
- cls_valid, cls_start_count, cls_finish_count  out  1  classifier input strobes
- cls_i, cls_q  out  DATA_WIDTH  classifier samples
- cls_valid_out, cls_finish_count_out, cls_count_condition  in  1  classifier outputs
- res_valid / res_ready  out / in  1  result handshake
- res_qubit  out  QUBIT_ID_WIDTH  measured qubit
- res_state  out  1  1 when res_count > threshold
- res_count  out  SAMPLE_COUNT_WIDTH  number of |1> decisions
- busy  out  1  state != IDLE

## Operation
- Coefficient table:
  - Registered; reset clears all entries to 0.
  - Writes are accepted in any state.
  - A load and a write to the same entry in the same cycle emit the old value; the new value applies to later loads.
- FSM states: IDLE, LOAD_B, LOAD_A, STREAM, DRAIN, RESULT.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch qubit, N and threshold; clear the accumulator and the sample counter.
  - If N == 0, go to RESULT (count 0, state 0). Otherwise go to LOAD_B.
- LOAD_B: cls_coeff_wr_en = 1, addr = 0, data = table[qubit].y_intercept; go to LOAD_A.
- LOAD_A: cls_coeff_wr_en = 1, addr = 1, data = table[qubit].slope; go to STREAM.
- STREAM:
  - cls_valid = iq_valid_in. cls_i/cls_q pass i_in/q_in combinationally.
  - cls_start_count is asserted with the first forwarded sample.
  - cls_finish_count is asserted with the Nth forwarded sample; go to DRAIN after it.
  - Samples arriving outside STREAM are dropped: cls_valid = 0 and the cls_i/cls_q values are don't-care.
- Accumulator (active in STREAM and DRAIN): increments on cls_valid_out & cls_count_condition. No overflow occurs, because N ≤ 2^SAMPLE_COUNT_WIDTH − 1.
- DRAIN: leave for RESULT on the cycle where cls_valid_out & cls_finish_count_out are both set; that sample's decision is included in the count.
- RESULT:
  - res_valid = 1 with res_qubit, res_count and res_state = (count > threshold). These values are held stable until res_ready.
  - On res_valid & res_ready, return to IDLE.
- All cls_* strobes are 0 outside the states listed above.

## Timing
- Request accepted at the edge ending cycle T:
  - LOAD_B during T+1, LOAD_A during T+2.
  - First sample can be forwarded in T+3.
- The classifier has a 2-cycle latency. If the last sample is forwarded in cycle S:
  - cls_finish_count_out arrives in S+2.
  - res_valid is high from S+3.
  - Minimum request-to-result time, with back-to-back samples, is N+5 cycles.
- req_ready is high only in IDLE, so a new request is accepted the cycle after the result handshake at the earliest.
- Reset:
  - Asynchronous; the FSM returns to IDLE immediately, abandoning any in-flight measurement.
  - Reset values: busy, res_valid, all cls_* strobes, cls_coeff_wr_data = 0; res_qubit, res_state, res_count = 0. req_ready = 1 once in IDLE.
  - The classifier's own rst flushes its pipeline, so no stale finish strobe reaches the sequencer.

## Test plan
- Table load: write q2 y_intercept = 0x0100 and slope = 0x4000. Request q2, N = 4. Expected: addr 0 with data 0x0100 in T+1, then addr 1 with data 0x4000 in T+2.
- Counting: N = 8, model the classifier so count_condition = 1 on 5 samples, threshold = 4. Expected: res_count = 5, res_state = 1, res_valid in S+3. Repeat with threshold = 5: res_state = 0.
- Gapped input: iq_valid_in toggles 1,0,1,0 during STREAM with N = 3. Expected: exactly 3 cls_valid pulses, start on the first pulse, finish on the third; no forwarding in the cycles before STREAM.
- Edge cases, N = 0 and N = 1:
  - N = 0: no coefficient writes and no cls_valid; res_valid at T+1 with count 0, state 0.
  - N = 1: start and finish on the same sample.
- Backpressure and collision:
  - Hold res_ready = 0 for 10 cycles: result stays stable, req_ready = 0.
  - Write q1 slope in the same cycle as LOAD_A for q1: the old slope is emitted, and the next request for q1 gets the new slope.
- Mid-operation reset: assert rst during STREAM after 3 of 8 samples. Expected: outputs are immediately 0 and busy = 0; a following request completes normally with a fresh count.
